// File: rtl/bsr_meta_pkg.sv
// Shared types and helpers for the BSR metadata server: address map base,
// FSM state encoding and the address-decode region.
package bsr_meta_pkg;

   localparam logic [31:0] COL_IDX_BASE = 32'd128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_RESP,
      ST_COOL
   } state_t;

   typedef enum logic [1:0] {
      RGN_ROW,
      RGN_COL,
      RGN_OOR
   } region_t;

   // row_ptr wins if a large ROW_PTR_DEPTH overlaps the col_idx window.
   // The col_idx bound is tested as an offset so base+depth cannot overflow.
   function automatic region_t decode_region(input logic [31:0] addr,
                                             input logic [31:0] row_depth,
                                             input logic [31:0] col_depth);
      region_t rgn;
      if (addr < row_depth)
         rgn = RGN_ROW;
      else if ((addr >= COL_IDX_BASE) && ((addr - COL_IDX_BASE) < col_depth))
         rgn = RGN_COL;
      else
         rgn = RGN_OOR;
      return rgn;
   endfunction

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/bsr_meta_if.sv
// Read/write bus of the BSR metadata server. The initiator uses the master
// modport; the server uses the slave modport.
interface bsr_meta_if #(
   parameter int unsigned DATA_W = 32
);
   logic              abort;
   logic              meta_ren;
   logic [31:0]       meta_raddr;
   logic              meta_ready;
   logic              meta_rvalid;
   logic [DATA_W-1:0] meta_rdata;
   logic              meta_err;
   logic              meta_wen;
   logic [31:0]       meta_waddr;
   logic [DATA_W-1:0] meta_wdata;
   logic [31:0]       rd_count;

   modport master (
      output abort, meta_ren, meta_raddr, meta_wen, meta_waddr, meta_wdata,
      input  meta_ready, meta_rvalid, meta_rdata, meta_err, rd_count
   );

   modport slave (
      input  abort, meta_ren, meta_raddr, meta_wen, meta_waddr, meta_wdata,
      output meta_ready, meta_rvalid, meta_rdata, meta_err, rd_count
   );
endinterface

// File: rtl/bsr_meta_ram.sv
// Synchronous 1R1W table RAM with a one-cycle registered read. The read
// register only updates when re is high, so it holds its last word otherwise.
module bsr_meta_ram #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 7
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array and read register have no reset; table contents must
   // survive rst_n, and a reset would stop this mapping onto block RAM.
   // NOTE: both ports use <=, so a write and a read of the same word on the
   // same edge return the old word.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/bsr_meta_server.sv
// BSR metadata server: row_ptr / col_idx tables behind a one-outstanding
// read FSM. Define BSR_META_PARITY_EN to add a per-word even-parity check.
module bsr_meta_server
   import bsr_meta_pkg::*;
#(
   parameter int unsigned ROW_PTR_DEPTH = 128,
   parameter int unsigned COL_IDX_DEPTH = 1024,
   parameter int unsigned DATA_W        = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   bsr_meta_if.slave  bus
);

   localparam int unsigned RA_W = addr_width(ROW_PTR_DEPTH);
   localparam int unsigned CA_W = addr_width(COL_IDX_DEPTH);
`ifdef BSR_META_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   state_t            state_q, state_d;
   logic [31:0]       raddr_q;
   region_t           rd_rgn, wr_rgn;
   logic              ready, rvalid, accept;
   logic              row_re, col_re, row_we, col_we;
   logic [MEM_W-1:0]  wr_word, row_rdata, col_rdata, sel_word;
   logic [DATA_W-1:0] resp_data, rdata_hold_q;
   logic              resp_err;
   logic [31:0]       rd_count_q;

   // ---------------------------------------------------------------- write path
   assign wr_rgn = decode_region(bus.meta_waddr, 32'(ROW_PTR_DEPTH), 32'(COL_IDX_DEPTH));
   assign row_we = bus.meta_wen && (wr_rgn == RGN_ROW);
   assign col_we = bus.meta_wen && (wr_rgn == RGN_COL);

`ifdef BSR_META_PARITY_EN
   // Stored bit makes the word's total popcount even.
   assign wr_word = {^bus.meta_wdata, bus.meta_wdata};
`else
   assign wr_word = bus.meta_wdata;
`endif

   bsr_meta_ram #(
      .DEPTH (ROW_PTR_DEPTH),
      .WIDTH (MEM_W),
      .AW    (RA_W)
   ) u_row_ram (
      .clk   (clk),
      .we    (row_we),
      .waddr (RA_W'(bus.meta_waddr)),
      .wdata (wr_word),
      .re    (row_re),
      .raddr (RA_W'(raddr_q)),
      .rdata (row_rdata)
   );

   bsr_meta_ram #(
      .DEPTH (COL_IDX_DEPTH),
      .WIDTH (MEM_W),
      .AW    (CA_W)
   ) u_col_ram (
      .clk   (clk),
      .we    (col_we),
      .waddr (CA_W'(bus.meta_waddr - COL_IDX_BASE)),
      .wdata (wr_word),
      .re    (col_re),
      .raddr (CA_W'(raddr_q - COL_IDX_BASE)),
      .rdata (col_rdata)
   );

   // ---------------------------------------------------------------- read FSM
   assign rd_rgn = decode_region(raddr_q, 32'(ROW_PTR_DEPTH), 32'(COL_IDX_DEPTH));
   assign accept = bus.meta_ren && ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_READ;
            ST_READ: state_d = ST_RESP;
            ST_RESP: state_d = ST_COOL;
            ST_COOL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      ready  = 1'b0;
      rvalid = 1'b0;
      row_re = 1'b0;
      col_re = 1'b0;
      unique case (state_q)
         ST_IDLE: ready  = !bus.abort;
         ST_READ: begin
            row_re = (rd_rgn == RGN_ROW);
            col_re = (rd_rgn == RGN_COL);
         end
         ST_RESP: rvalid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         raddr_q <= '0;
      else if (accept)
         raddr_q <= bus.meta_raddr;
   end

   // ---------------------------------------------------------------- response
   always_comb begin
      sel_word = '0;
      resp_err = 1'b0;
      unique case (rd_rgn)
         RGN_ROW: sel_word = row_rdata;
         RGN_COL: sel_word = col_rdata;
         default: resp_err = 1'b1;
      endcase
`ifdef BSR_META_PARITY_EN
      if (^sel_word)
         resp_err = 1'b1;
`endif
      resp_data = sel_word[DATA_W-1:0];
   end

   // Consumers sample rdata a cycle after rvalid, so the word is held until
   // the next response replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_hold_q <= '0;
         rd_count_q   <= '0;
      end else if (rvalid) begin
         rdata_hold_q <= resp_data;
         rd_count_q   <= rd_count_q + 32'd1;
      end
   end

   assign bus.meta_ready  = ready;
   assign bus.meta_rvalid = rvalid;
   assign bus.meta_rdata  = rvalid ? resp_data : rdata_hold_q;
   assign bus.meta_err    = rvalid && resp_err;
   assign bus.rd_count    = rd_count_q;

endmodule

// File: tb/tb_bsr_meta_server.sv
// Scoreboard bench for bsr_meta_server: directed scenarios then random
// traffic, checked against an array-based model of the two tables.
module tb_bsr_meta_server;

   localparam int ROW  = 128;
   localparam int COL  = 1024;
   localparam int BASE = 128;
   localparam int DW   = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bsr_meta_if #(.DATA_W(DW)) bus ();

   bsr_meta_server #(
      .ROW_PTR_DEPTH (ROW),
      .COL_IDX_DEPTH (COL),
      .DATA_W        (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [31:0] row_m [ROW];
   logic [31:0] col_m [COL];
   bit          row_bad [ROW];
   int          busy = 0;   // cycles left before the server is ready again

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model_read(input logic [31:0] a);
      exp_t e;
      e.cyc = 0;
      if (a < ROW) begin
         e.data = row_m[7'(a)];
         e.err  = row_bad[7'(a)];
      end else if (a >= BASE && a < BASE + COL) begin
         e.data = col_m[10'(a - BASE)];
         e.err  = 1'b0;
      end else begin
         e.data = '0;
         e.err  = 1'b1;
      end
      return e;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
      if (a < ROW) begin
         row_m[7'(a)]   = d;
         row_bad[7'(a)] = 1'b0;
      end else if (a >= BASE && a < BASE + COL) begin
         col_m[10'(a - BASE)] = d;
      end
   endfunction

   // One clock cycle: check readiness against the model, then at the edge
   // account for this cycle's write, acceptance and abort.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (rst_n)
         check("meta_ready", {31'b0, bus.meta_ready}, {31'b0, busy == 0});
      @(posedge clk);
      if (rst_n) begin
         if (bus.meta_wen)
            model_write(bus.meta_waddr, bus.meta_wdata);
         if (busy == 0) begin
            if (bus.meta_ren) begin
               e     = model_read(bus.meta_raddr);
               e.cyc = cyc + 2;
               sb.push_back(e);
               busy  = 3;
            end
         end else if (bus.abort) begin
            if (busy == 3)
               void'(sb.pop_back());
            busy = 0;
         end else begin
            busy--;
         end
      end
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      bus.meta_wen   = 1'b1;
      bus.meta_waddr = a;
      bus.meta_wdata = d;
      step();
      bus.meta_wen   = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a);
      bus.meta_ren   = 1'b1;
      bus.meta_raddr = a;
      step();
      bus.meta_ren   = 1'b0;
      repeat (3) step();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0:       a = 32'(BASE + COL) + 32'($urandom_range(0, 200));
         1:       a = $urandom | 32'h8000_0000;
         default: a = 32'($urandom_range(0, BASE + COL - 1));
      endcase
      return a;
   endfunction

   // ---------------------------------------------------------------- monitor
   exp_t        mon_e;
   logic [31:0] last_data  = '0;
   bit          prev_valid = 1'b0;
   int          n_seen     = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         last_data  = '0;
         prev_valid = 1'b0;
         n_seen     = 0;
      end else begin
         if (prev_valid)
            check("rd_count", bus.rd_count, n_seen);
         if (bus.meta_rvalid) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rvalid: got rvalid at cycle %0d, expected none", cyc);
            end else begin
               mon_e = sb.pop_front();
               check("rvalid_cycle", cyc, mon_e.cyc);
               check("meta_rdata", bus.meta_rdata, mon_e.data);
               check("meta_err", {31'b0, bus.meta_err}, {31'b0, mon_e.err});
               last_data = mon_e.data;
            end
            n_seen++;
         end else begin
            check("rdata_hold", bus.meta_rdata, last_data);
            check("err_idle", {31'b0, bus.meta_err}, 32'd0);
         end
         prev_valid = bus.meta_rvalid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      bus.abort      = 1'b0;
      bus.meta_ren   = 1'b0;
      bus.meta_raddr = '0;
      bus.meta_wen   = 1'b0;
      bus.meta_waddr = '0;
      bus.meta_wdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rvalid", {31'b0, bus.meta_rvalid}, 32'd0);
      check("rst_err", {31'b0, bus.meta_err}, 32'd0);
      check("rst_rdata", bus.meta_rdata, 32'd0);
      check("rst_rd_count", bus.rd_count, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Fill every table word so any in-range read has a known value.
      for (int i = 0; i < BASE + COL; i++)
         do_write(32'(i), $urandom);
      do_write(32'd3, 32'd5);
      do_write(32'd4, 32'd9);

      // Held ren: addr 3 for four cycles, then addr 4 -> two responses.
      bus.meta_ren   = 1'b1;
      bus.meta_raddr = 32'd3;
      repeat (4) step();
      bus.meta_raddr = 32'd4;
      step();
      bus.meta_ren   = 1'b0;
      repeat (4) step();
      check("rd_count_two", bus.rd_count, 32'd2);

      do_read(32'd3);

      // col_idx through the shared map, and the first address past it.
      do_write(32'd130, 32'h7);
      do_read(32'd130);
      do_read(32'(BASE + COL));

      // Abort while in READ: no response, ready two cycles after acceptance.
      bus.meta_ren   = 1'b1;
      bus.meta_raddr = 32'd4;
      step();
      bus.meta_ren   = 1'b0;
      bus.abort      = 1'b1;
      step();
      bus.abort      = 1'b0;
      step();
      do_read(32'd4);

      // Abort coinciding with RESP still delivers that response.
      bus.meta_ren   = 1'b1;
      bus.meta_raddr = 32'd130;
      step();
      bus.meta_ren   = 1'b0;
      step();
      bus.abort      = 1'b1;
      step();
      bus.abort      = 1'b0;
      repeat (2) step();

      // Write to the word being read in its RAM-access cycle -> old data.
      do_write(32'd3, 32'd5);
      bus.meta_ren   = 1'b1;
      bus.meta_raddr = 32'd3;
      step();
      bus.meta_ren   = 1'b0;
      bus.meta_wen   = 1'b1;
      bus.meta_waddr = 32'd3;
      bus.meta_wdata = 32'h11;
      step();
      bus.meta_wen   = 1'b0;
      repeat (2) step();
      do_read(32'd3);

      // Reset in the middle of a read: dropped, tables preserved.
      bus.meta_ren   = 1'b1;
      bus.meta_raddr = 32'd4;
      step();
      bus.meta_ren   = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      busy = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_rvalid", {31'b0, bus.meta_rvalid}, 32'd0);
      check("midrst_rd_count", bus.rd_count, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      do_read(32'd4);

`ifdef BSR_META_PARITY_EN
      dut.u_row_ram.mem[7][DW] = ~dut.u_row_ram.mem[7][DW];
      row_bad[7] = 1'b1;
      do_read(32'd7);
`endif

      // Random traffic: writes, reads and aborts in any phase of a read.
      for (int n = 0; n < 3000; n++) begin
         bus.meta_wen   = 1'($urandom_range(0, 1));
         bus.meta_waddr = rand_addr();
         bus.meta_wdata = $urandom;
         bus.meta_ren   = 1'($urandom_range(0, 1));
         bus.meta_raddr = rand_addr();
         bus.abort      = (busy != 0) && ($urandom_range(0, 15) == 0);
         step();
      end
      bus.meta_wen = 1'b0;
      bus.meta_ren = 1'b0;
      bus.abort    = 1'b0;

      for (int k = 0; k < 20 && (sb.size() != 0 || busy != 0); k++)
         step();
      repeat (2) step();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("final_rd_count", bus.rd_count, 32'(n_seen));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
